// File: rtl/omux_arbiter_pkg.sv
// omux_pkg: shared FSM state type and constants for the omux record path.
package omux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HDR    = 2'd2,
        ST_XFER   = 2'd3
    } omux_state_e;

    localparam logic [3:0] OMUX_HDR_TAG = 4'hA;
    localparam int         OMUX_MAX_SRC = 16;

    // Index width for n sources; never below one bit so single-source builds still have a vector.
    function automatic int omux_idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/omux_arbiter_if.sv
// omux_arbiter_if: record-source bus plus downstream byte-sink handshake.
// master = arbiter side, slave = sources/sink side.
interface omux_arbiter_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0] omux_req_i;
    logic [NSRC-1:0] omux_sel_o;
    logic [7:0]      omux_data_i;
    logic [7:0]      dout_o;
    logic            dout_valid_o;
    logic            dout_ready_i;
    logic            rec_done_o;
    logic            abort_o;

    modport master (
        input  omux_req_i, omux_data_i, dout_ready_i,
        output omux_sel_o, dout_o, dout_valid_o, rec_done_o, abort_o
    );

    modport slave (
        output omux_req_i, omux_data_i, dout_ready_i,
        input  omux_sel_o, dout_o, dout_valid_o, rec_done_o, abort_o
    );
endinterface

// File: rtl/omux_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Returns the first set request
// at or after ptr, wrapping circularly.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);
    logic [N-1:0] rot;

    // Rotate so bit k of rot is request (ptr+k) mod N.
    assign rot = N'({req, req} >> ptr);

    // Scan from the far end so the smallest offset is the last writer.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = PW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/omux_arbiter.sv
// omux_arbiter: grants one record source at a time, strobes its select to
// drain one record byte-by-byte and forwards the bytes to a valid/ready sink.
// Optional OMUX_HEADER_EN: prefix each record with {4'hA, grant}.
module omux_arbiter
    import omux_pkg::*;
#(
    parameter int NSRC      = 4,
    parameter int REC_BYTES = 16
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    omux_arbiter_if.master bus
);
    localparam int PW = omux_idx_w(NSRC);
    localparam int CW = $clog2(REC_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(REC_BYTES - 1);

    omux_state_e     state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d, grant_q, grant_d, grant_inc, pick_idx;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      dout_q, dout_d;
    logic            dv_q, dv_d, done_q, done_d, abort_q, abort_d;
    logic            pick_found, req_g, slot_free;
    logic [NSRC-1:0] sel;

    rr_pick #(.N(NSRC), .PW(PW)) u_pick (
        .req   (bus.omux_req_i),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign req_g     = bus.omux_req_i[grant_q];
    assign slot_free = !dv_q || bus.dout_ready_i;
    assign grant_inc = (grant_q == PW'(NSRC - 1)) ? '0 : grant_q + PW'(1);

    // Next-state, select strobe and output-register load decisions.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        dv_d    = dv_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        sel     = '0;
        // An accepted byte frees the register unless a new one lands below.
        if (dv_q && bus.dout_ready_i) dv_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Source gave up before shifting anything: quiet return.
                if (!req_g) state_d = ST_IDLE;
`ifdef OMUX_HEADER_EN
                else state_d = ST_HDR;
`else
                else state_d = ST_XFER;
`endif
            end
`ifdef OMUX_HEADER_EN
            ST_HDR: begin
                if (!req_g) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = grant_inc;
                    state_d = ST_IDLE;
                end else if (slot_free) begin
                    dout_d  = {OMUX_HDR_TAG, 4'(grant_q)};
                    dv_d    = 1'b1;
                    state_d = ST_XFER;
                end
            end
`endif
            ST_XFER: begin
                if (!req_g) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    ptr_d   = grant_inc;
                    state_d = ST_IDLE;
                end else if (slot_free) begin
                    sel[grant_q] = 1'b1;
                    dout_d       = bus.omux_data_i;
                    dv_d         = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        ptr_d   = grant_inc;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops select and valid immediately.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign bus.omux_sel_o   = sel;
    assign bus.dout_o       = dout_q;
    assign bus.dout_valid_o = dv_q;
    assign bus.rec_done_o   = done_q;
    assign bus.abort_o      = abort_q;
endmodule

// File: tb/tb_omux_arbiter.sv
// tb_omux_arbiter: source/sink environment, record-level round-robin model
// and a byte/event scoreboard checked by an independent monitor.
module tb_omux_arbiter;
    localparam int NSRC = 4;
    localparam int REC  = 16;
`ifdef OMUX_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    omux_arbiter_if #(.NSRC(NSRC)) bus ();
    omux_arbiter #(.NSRC(NSRC), .REC_BYTES(REC)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit in_rst = 1'b1;

    // source environment
    int idx[NSRC];
    bit active[NSRC];
    int recs[NSRC];
    int drop_at[NSRC];
    int cool[NSRC];
    int drop_pct = 0;
    int max_cool = 1;
    int ready_mode = 0;
    logic [NSRC-1:0] sel_prev;

    // reference model
    bit idle_m = 1'b1;
    int ptr_m = 0, g_m = 0, dec_cyc = 0, nshift = 0;
    logic [7:0] exp_q[$];
    int ev_q[$];   // 1 = record done, 2 = abort

    // shared bus: driven by whichever source is selected
    always_comb begin
        bus.omux_data_i = 8'h00;
        for (int s = 0; s < NSRC; s++)
            if (bus.omux_sel_o[s]) bus.omux_data_i = 8'(s * 16 + idx[s]);
    end

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(string name, string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic int rr_ref(logic [NSRC-1:0] req, int ptr);
        for (int i = 0; i < NSRC; i++)
            if (req[(ptr + i) % NSRC]) return (ptr + i) % NSRC;
        return -1;
    endfunction

    task automatic model(logic [NSRC-1:0] sel);
        bit window;
        if (sel != 0) begin
            check("sel_grant", int'(sel), idle_m ? 0 : (1 << g_m));
            if (!idle_m && nshift == 0 && ready_mode == 0)
                check("grant_latency", cyc - dec_cyc, 2 + HDR);
        end
        window = !idle_m && bus.omux_req_i[g_m] && bus.dout_ready_i &&
                 (nshift > 0 || (HDR == 0 && cyc >= dec_cyc + 2));
        if (window) check("sel_when_free", int'(sel[g_m]), 1);
        if (idle_m && bus.omux_req_i != 0) begin
            g_m = rr_ref(bus.omux_req_i, ptr_m);
            idle_m = 1'b0;
            dec_cyc = cyc;
            nshift = 0;
            if (HDR != 0) exp_q.push_back(8'hA0 | 8'(g_m));
            for (int i = 0; i < REC; i++) exp_q.push_back(8'(g_m * 16 + i));
        end else if (!idle_m) begin
            if (sel[g_m]) begin
                nshift++;
                if (nshift == REC) begin
                    ev_q.push_back(1);
                    ptr_m = (g_m + 1) % NSRC;
                    idle_m = 1'b1;
                    if (ready_mode == 0) check("record_cycles", cyc - dec_cyc + 1, REC + 2 + HDR);
                end
            end else if (!bus.omux_req_i[g_m] && nshift > 0) begin
                for (int i = 0; i < REC - nshift; i++) exp_q.delete(exp_q.size() - 1);
                ev_q.push_back(2);
                ptr_m = (g_m + 1) % NSRC;
                idle_m = 1'b1;
            end
        end
    endtask

    task automatic step();
        logic r;
        logic [NSRC-1:0] sel;
        @(negedge clk);
        cyc++;
        for (int s = 0; s < NSRC; s++) begin
            if (sel_prev[s]) begin
                idx[s]++;
                if (idx[s] == REC || (drop_at[s] != 0 && idx[s] == drop_at[s])) begin
                    active[s] = 1'b0;
                    idx[s] = 0;
                    drop_at[s] = 0;
                    recs[s]--;
                    cool[s] = $urandom_range(max_cool, 1);
                end
            end
            if (!active[s] && recs[s] > 0) begin
                if (cool[s] > 0) cool[s]--;
                else begin
                    active[s] = 1'b1;
                    if ($urandom_range(99, 0) < drop_pct) drop_at[s] = $urandom_range(REC - 1, 1);
                end
            end
            bus.omux_req_i[s] = active[s];
        end
        case (ready_mode)
            0: r = 1'b1;
            1: r = !bus.dout_ready_i;
            default: r = 1'($urandom_range(1, 0));
        endcase
        bus.dout_ready_i = r;
        #1;
        sel = bus.omux_sel_o;
        if (!in_rst) model(sel);
        sel_prev = sel;
    endtask

    function automatic bit quiet();
        for (int s = 0; s < NSRC; s++)
            if (recs[s] != 0 || active[s]) return 1'b0;
        return idle_m && exp_q.size() == 0 && ev_q.size() == 0;
    endfunction

    task automatic drain(int budget, string name);
        int n = 0;
        while (!quiet() && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail(name, "did not drain within cycle budget");
        repeat (2) step();
    endtask

    // monitor: pops the scoreboard whenever the DUT hands over a byte or pulses
    always @(negedge clk) begin
        #2;
        if (!in_rst) begin
            if (bus.dout_valid_o && bus.dout_ready_i) begin
                if (exp_q.size() == 0) fail("dout", $sformatf("unexpected byte 0x%0h", bus.dout_o));
                else check("dout", int'(bus.dout_o), int'(exp_q.pop_front()));
            end
            if (bus.rec_done_o || bus.abort_o) begin
                if (ev_q.size() == 0) fail("event", "unexpected done/abort pulse");
                else check("event", int'({bus.abort_o, bus.rec_done_o}), ev_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_sel"},   int'(bus.omux_sel_o), 0);
        check({tag, "_dout"},  int'(bus.dout_o), 0);
        check({tag, "_valid"}, int'(bus.dout_valid_o), 0);
        check({tag, "_done"},  int'(bus.rec_done_o), 0);
        check({tag, "_abort"}, int'(bus.abort_o), 0);
    endtask

    initial begin
        int n;
        for (int s = 0; s < NSRC; s++) begin
            idx[s] = 0; active[s] = 1'b0; recs[s] = 0; drop_at[s] = 0; cool[s] = 0;
        end
        bus.omux_req_i = '0;
        bus.dout_ready_i = 1'b0;
        sel_prev = '0;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_rst = 1'b0;

        // single record from src1, sink always ready
        recs[1] = 1;
        drain(200, "t1_single");
        // src0 and src2 competing continuously
        recs[0] = 4; recs[2] = 4;
        drain(400, "t2_alternate");
        // sink ready toggling
        ready_mode = 1;
        recs[2] = 1;
        drain(200, "t3_toggle");
        // src3 drops after 5 bytes; others join while it is granted
        ready_mode = 0;
        drop_at[3] = 5;
        recs[3] = 1;
        n = 0;
        while (idle_m && n < 50) begin step(); n++; end
        if (n >= 50) fail("t4_grant", "src3 never granted");
        recs[0] = 1; recs[1] = 1;
        drain(300, "t4_abort");
        // randomized traffic
        drop_pct = 15; max_cool = 4; ready_mode = 2;
        for (int s = 0; s < NSRC; s++) recs[s] = $urandom_range(4, 1);
        drain(6000, "random");
        // reset mid-record: leave pointer at 1, then break src1's record
        drop_pct = 0; max_cool = 1; ready_mode = 0;
        recs[0] = 1;
        drain(200, "pre_rst");
        recs[1] = 1;
        n = 0;
        while (idx[1] < 7 && n < 200) begin step(); n++; end
        if (n >= 200) fail("rst_reach", "src1 never reached byte 7");
        rst_n = 1'b0;
        in_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        for (int s = 0; s < NSRC; s++) begin
            idx[s] = 0; active[s] = 1'b0; recs[s] = 0; drop_at[s] = 0; cool[s] = 0;
        end
        bus.omux_req_i = '0;
        sel_prev = '0;
        idle_m = 1'b1;
        ptr_m = 0;
        exp_q.delete();
        ev_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_rst = 1'b0;
        for (int s = 0; s < NSRC; s++) recs[s] = 1;
        drain(400, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/omux_arbiter.md
# omux_arbiter

Output-side arbiter and byte collector for the record-buffer output-mux (omux) protocol. It grants one of `NSRC` byte-serializing record sources at a time, strobes that source's select line to drain exactly one record byte-by-byte from the shared 8-bit omux data bus, and forwards the bytes to a downstream valid/ready byte sink (host FIFO / USB bridge). It sits between the per-channel record buffers and the host link, and is the consumer end of `omux_req`/`omux_sel`/`omux_data`.

## Interface
- `NSRC`, default 4: number of record sources; 1..16.
- `REC_BYTES`, default 16: record length in bytes; ≥1; identical for all sources.
- `clk_i`  in  1: system clock.
- `rst_n_i`  in  1: asynchronous reset, active-low.
- `omux_req_i`  in  NSRC: per-source request; high while that source holds a record ready to shift.
- `omux_sel_o`  out  NSRC: per-source select, at most one bit high (one-hot or zero); a high bit means "byte valid on bus this cycle, advance".
- `omux_data_i`  in  8: shared bus byte, driven by the selected source, valid only while its `omux_sel_o` bit is high.
- `dout_o`  out  8: byte to sink.
- `dout_valid_o`  out  1: `dout_o` is valid.
- `dout_ready_i`  in  1: sink accepts the byte when valid && ready.
- `rec_done_o`  out  1: one-cycle pulse when a full record has been drained.
- `abort_o`  out  1: one-cycle pulse when the granted source dropped request mid-record.

## Operation
- Reset values: `omux_sel_o`=0, `dout_o`=0, `dout_valid_o`=0, `rec_done_o`=0, `abort_o`=0, state=IDLE, round-robin pointer=0, byte count=0, grant=0.
- States:
  - IDLE: if any `omux_req_i` is high, choose the first requesting index at or after the pointer (circular), register it as grant, go to SETTLE. Otherwise stay.
  - SETTLE: one cycle, all sel low, so the source can load its shift register. Next state is HDR if `OMUX_HEADER_EN`, else XFER.
  - HDR: emits the header byte into the output register under the same backpressure rule as XFER, without asserting sel, then goes to XFER.
  - XFER: `omux_sel_o[grant] = omux_req_i[grant] && (!dout_valid_o || dout_ready_i)`.
    - Each sel-high cycle: `dout_o <= omux_data_i`, `dout_valid_o <= 1`, byte count increments.
    - Sel on count==`REC_BYTES`-1: count clears, `rec_done_o` pulses next cycle, pointer <= (grant+1) mod `NSRC`, state goes to IDLE.
- Abort: `omux_req_i[grant]` low in XFER (or HDR) with bytes outstanding.
  - No sel that cycle; `abort_o` pulses next cycle.
  - Count clears, pointer <= grant+1, state goes to IDLE.
  - Bytes already forwarded are not retracted.
- Request dropping during SETTLE: go to IDLE with no abort pulse and no pointer change.
- Output register: cleared (`dout_valid_o` <= 0) on valid && ready when no new byte is loaded the same cycle. Simultaneous accept and load keeps valid high with the new byte.
- Count width: `$clog2(REC_BYTES+1)`. Pointer and grant width: `$clog2(NSRC)` (minimum 1).

## Timing
- Grant latency: req rising in IDLE → sel can first assert 2 cycles later (IDLE → SETTLE → XFER), or 3 cycles with the header.
- Byte latency: sel cycle N → `dout_valid_o` with that byte at cycle N+1.
- Throughput: with the sink always ready, a record takes `REC_BYTES`+2 cycles (+1 with header). The next grant is evaluated in the first IDLE cycle after done.
- `omux_sel_o` is combinational from `dout_ready_i`, `omux_req_i`, and registered state. No other combinational in→out paths.
- Reset assertion mid-record: all outputs go to their reset values immediately. The source sees sel drop and must tolerate a partially shifted record.

## Configuration
- `OMUX_HEADER_EN` defined: each record is preceded by one header byte `{4'hA, grant[3:0]}` (grant zero-extended). Records are `REC_BYTES`+1 bytes on `dout_o`.
- `OMUX_HEADER_EN` undefined: no HDR state. Records are exactly `REC_BYTES` bytes, with no source tagging.

## Structure
- Shared package `omux_pkg`:
  - state enum (IDLE, SETTLE, HDR, XFER);
  - `OMUX_HDR_TAG` = 4'hA;
  - `OMUX_MAX_SRC` = 16.
- One natural sub-module: `rr_pick`. It is combinational and takes request vector plus pointer, returning found flag and index. It is reusable by other arbiters.

## Test plan
- NSRC=4, REC_BYTES=16, src1 requests with bytes 0x10..0x1F, sink always ready → sel[1] high 16 consecutive cycles starting 2 cycles after req; `dout_o` 0x10..0x1F in order; one `rec_done_o`.
- Sources 0 and 2 request continuously → grants alternate 0,2,0,2; never two sel bits high; 18 cycles per record.
- Sink ready toggles 1,0,1,0 during XFER → sel only on cycles where the output register frees; all 16 bytes delivered once, no drops or duplicates.
- Src3 drops req after 5 bytes → `abort_o` pulses once; pointer advances to 0; no `rec_done_o`; next grant goes to a requesting source.
- With `OMUX_HEADER_EN`, src2 record → first byte 0xA2 then 16 data bytes; done after 19 cycles.
- `rst_n_i` pulled low after byte 7 → sel and valid go to 0 asynchronously; after release, a new request restarts cleanly from count 0 and pointer 0.
